// File: rtl/pim_mmio_ctrl_if.sv
// CPU data-bus and PIM handshake bundle for pim_mmio_ctrl.
// slave = controller view, master = CPU/PIM side view.
interface pim_mmio_ctrl_if;
  logic [31:0] DADDR;
  logic [31:0] DATAO;
  logic [3:0]  BE;
  logic        WR;
  logic        RD;
  logic [31:0] DATAI;
  logic        HLT;
  logic        pim_cmd_valid;
  logic        pim_cmd_ready;
  logic [31:0] pim_cmd_data;
  logic        pim_rsp_valid;
  logic        pim_rsp_ready;
  logic [31:0] pim_rsp_data;
  logic        IRQ;

  modport slave (
    input  DADDR, DATAO, BE, WR, RD, pim_cmd_ready, pim_rsp_valid, pim_rsp_data,
    output DATAI, HLT, pim_cmd_valid, pim_cmd_data, pim_rsp_ready, IRQ
  );

  modport master (
    output DADDR, DATAO, BE, WR, RD, pim_cmd_ready, pim_rsp_valid, pim_rsp_data,
    input  DATAI, HLT, pim_cmd_valid, pim_cmd_data, pim_rsp_ready, IRQ
  );
endinterface

// File: rtl/pim_mmio_ctrl.sv
// MMIO command/response bridge between the darkriscv data bus and a PIM macro.
// Optional done interrupt and IRQEN register enabled by defining PIM_IRQ_EN.
module pim_mmio_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int unsigned CMD_DEPTH = 8,
  parameter int unsigned RSP_DEPTH = 8
) (
  input logic             CLK,
  input logic             RES,
  pim_mmio_ctrl_if.slave  bus
);

  localparam int unsigned CPW = $clog2(CMD_DEPTH);
  localparam int unsigned CCW = CPW + 1;
  localparam int unsigned RPW = $clog2(RSP_DEPTH);
  localparam int unsigned RCW = RPW + 1;

  localparam logic [2:0] OffCtrl   = 3'd0;
  localparam logic [2:0] OffStatus = 3'd1;
  localparam logic [2:0] OffCmd    = 3'd2;
  localparam logic [2:0] OffRsp    = 3'd3;
  localparam logic [2:0] OffIrqen  = 3'd4;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e           r_state;
  logic [CCW-1:0]   r_out;
  logic             r_done;
  logic             r_cmd_valid;
  logic [31:0]      r_datai;

  logic [31:0]      r_cmd_mem [CMD_DEPTH];
  logic [CPW-1:0]   r_cmd_wp, r_cmd_rp;
  logic [CCW-1:0]   r_cmd_cnt;
  logic [31:0]      r_rsp_mem [RSP_DEPTH];
  logic [RPW-1:0]   r_rsp_wp, r_rsp_rp;
  logic [RCW-1:0]   r_rsp_cnt;

  logic             w_sel, w_wr, w_rd;
  logic [2:0]       w_off;
  logic             w_clr, w_go, w_done_w1c;
  logic             w_cmd_req, w_cmd_push, w_cmd_pop, w_cmd_full, w_cmd_empty;
  logic             w_rsp_push, w_rsp_pop, w_rsp_full, w_rsp_empty;
  logic [CCW-1:0]   w_cmd_cnt_d;
  logic [RCW-1:0]   w_rsp_cnt_d;
  logic [31:0]      w_status, w_rdata;
  logic             w_irqen_bit;
  logic             w_unused;

  // Address decode; all registers are word-only, partial writes are dropped.
  assign w_sel      = (bus.DADDR[31:5] == BASE_ADDR[31:5]);
  assign w_off      = bus.DADDR[4:2];
  assign w_wr       = bus.WR & w_sel & (bus.BE == 4'hF);
  assign w_rd       = bus.RD & w_sel;
  assign w_clr      = w_wr & (w_off == OffCtrl) & bus.DATAO[1];
  assign w_go       = w_wr & (w_off == OffCtrl) & bus.DATAO[0] & ~w_clr;
  assign w_done_w1c = w_wr & (w_off == OffStatus) & bus.DATAO[4];
  assign w_unused   = ^bus.DADDR[1:0];

  assign w_cmd_full  = (r_cmd_cnt == CCW'(CMD_DEPTH));
  assign w_cmd_empty = (r_cmd_cnt == '0);
  assign w_rsp_full  = (r_rsp_cnt == RCW'(RSP_DEPTH));
  assign w_rsp_empty = (r_rsp_cnt == '0);

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_cmd_req  = w_wr & (w_off == OffCmd);
  assign w_cmd_pop  = r_cmd_valid & bus.pim_cmd_ready;
  assign w_cmd_push = w_cmd_req & (~w_cmd_full | w_cmd_pop);
  assign w_rsp_push = bus.pim_rsp_valid & ~w_rsp_full & ((r_state == StIssue) |
                      (r_state == StWait));
  assign w_rsp_pop  = w_rd & (w_off == OffRsp) & ~w_rsp_empty;

  always_comb begin
    w_cmd_cnt_d = r_cmd_cnt;
    if (w_cmd_push && !w_cmd_pop) w_cmd_cnt_d = r_cmd_cnt + CCW'(1);
    else if (!w_cmd_push && w_cmd_pop) w_cmd_cnt_d = r_cmd_cnt - CCW'(1);
    if (w_clr) w_cmd_cnt_d = '0;
  end

  always_comb begin
    w_rsp_cnt_d = r_rsp_cnt;
    if (w_rsp_push && !w_rsp_pop) w_rsp_cnt_d = r_rsp_cnt + RCW'(1);
    else if (!w_rsp_push && w_rsp_pop) w_rsp_cnt_d = r_rsp_cnt - RCW'(1);
    if (w_clr) w_rsp_cnt_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (w_cmd_push) r_cmd_mem[r_cmd_wp] <= bus.DATAO;
    if (w_rsp_push) r_rsp_mem[r_rsp_wp] <= bus.pim_rsp_data;
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_cmd_wp  <= '0;
      r_cmd_rp  <= '0;
      r_cmd_cnt <= '0;
      r_rsp_wp  <= '0;
      r_rsp_rp  <= '0;
      r_rsp_cnt <= '0;
    end else begin
      r_cmd_cnt <= w_cmd_cnt_d;
      r_rsp_cnt <= w_rsp_cnt_d;
      if (w_clr) begin
        r_cmd_wp <= '0;
        r_cmd_rp <= '0;
        r_rsp_wp <= '0;
        r_rsp_rp <= '0;
      end else begin
        if (w_cmd_push) r_cmd_wp <= r_cmd_wp + CPW'(1);
        if (w_cmd_pop)  r_cmd_rp <= r_cmd_rp + CPW'(1);
        if (w_rsp_push) r_rsp_wp <= r_rsp_wp + RPW'(1);
        if (w_rsp_pop)  r_rsp_rp <= r_rsp_rp + RPW'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_state     <= StIdle;
      r_out       <= '0;
      r_done      <= 1'b0;
      r_cmd_valid <= 1'b0;
    end else if (w_clr) begin
      r_state     <= StIdle;
      r_out       <= '0;
      r_done      <= 1'b0;
      r_cmd_valid <= 1'b0;
    end else begin
      if (w_done_w1c) r_done <= 1'b0;
      if (w_cmd_pop && !w_rsp_push) r_out <= r_out + CCW'(1);
      else if (!w_cmd_pop && w_rsp_push && (r_out != '0)) r_out <= r_out - CCW'(1);
      case (r_state)
        StIdle: begin
          if (w_go) begin
            if (w_cmd_empty) begin
              r_done <= 1'b1;
            end else begin
              r_state     <= StIssue;
              r_cmd_valid <= 1'b1;
            end
          end
        end
        StIssue: begin
          // Late CMD writes keep the run in ISSUE until the FIFO really drains.
          if (w_cmd_cnt_d == '0) begin
            r_state     <= StWait;
            r_cmd_valid <= 1'b0;
          end
        end
        StWait: begin
          if (r_out == '0) r_state <= StDone;
        end
        StDone: begin
          r_done  <= 1'b1;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign w_status = {8'd0, 8'(r_rsp_cnt), 8'(r_cmd_cnt), 3'd0, r_done, ~w_rsp_empty,
                     w_cmd_empty, w_cmd_full, (r_state != StIdle)};

  always_comb begin
    w_rdata = '0;
    case (w_off)
      OffStatus: w_rdata = w_status;
      OffRsp:    w_rdata = w_rsp_empty ? 32'd0 : r_rsp_mem[r_rsp_rp];
      OffIrqen:  w_rdata = {31'd0, w_irqen_bit};
      default:   w_rdata = '0;
    endcase
  end

  // DATAI is zero whenever unselected so it can be OR-muxed with the RAM.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) r_datai <= '0;
    else     r_datai <= w_rd ? w_rdata : 32'd0;
  end

`ifdef PIM_IRQ_EN
  logic r_irqen;
  logic r_irq;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_irqen <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (w_wr && (w_off == OffIrqen)) r_irqen <= bus.DATAO[0];
      r_irq <= r_done & r_irqen & ~w_done_w1c & ~w_clr;
    end
  end

  assign w_irqen_bit = r_irqen;
  assign bus.IRQ     = r_irq;
`else
  assign w_irqen_bit = 1'b0;
  assign bus.IRQ     = 1'b0;
`endif

  assign bus.DATAI         = r_datai;
  assign bus.HLT           = w_cmd_req & w_cmd_full & ~w_cmd_pop;
  assign bus.pim_cmd_valid = r_cmd_valid;
  assign bus.pim_cmd_data  = r_cmd_mem[r_cmd_rp];
  assign bus.pim_rsp_ready = ~w_rsp_full;

endmodule

// File: tb/tb_pim_mmio_ctrl.sv
// Directed bench for pim_mmio_ctrl: CPU bus tasks plus a PIM echo model (data+1).
module tb_pim_mmio_ctrl;
  localparam logic [31:0] Base = 32'h0000_0400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pim_mmio_ctrl_if bus ();

  pim_mmio_ctrl #(
    .BASE_ADDR (Base),
    .CMD_DEPTH (8),
    .RSP_DEPTH (8)
  ) u_dut (
    .CLK (clk),
    .RES (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // PIM model: accepts commands when pim_ready, answers data+1 after rsp_lat cycles.
  logic        pim_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data  = '0;
  logic [31:0] rq_d[$];
  int          rq_t[$];
  logic [31:0] issued[$];
  int          cyc = 0;
  int          rsp_lat = 2;
  int          n_hs = 0;

  assign bus.pim_cmd_ready = pim_ready;
  assign bus.pim_rsp_valid = rsp_valid;
  assign bus.pim_rsp_data  = rsp_data;

  always @(posedge clk) begin
    if (bus.pim_rsp_valid && bus.pim_rsp_ready) begin
      void'(rq_d.pop_front());
      void'(rq_t.pop_front());
      n_hs++;
    end
    if (bus.pim_cmd_valid && bus.pim_cmd_ready) begin
      rq_d.push_back(bus.pim_cmd_data + 32'd1);
      rq_t.push_back(cyc + rsp_lat);
      issued.push_back(bus.pim_cmd_data);
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (rq_d.size() > 0 && rq_t[0] <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = rq_d[0];
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = '0;
    end
  end

  task automatic bus_wr(input logic [7:0] off, input logic [31:0] d,
                        input logic [3:0] be = 4'hF);
    bus.DADDR = Base + 32'(off);
    bus.DATAO = d;
    bus.BE    = be;
    bus.WR    = 1'b1;
    @(negedge clk);
    bus.WR    = 1'b0;
    bus.BE    = 4'hF;
  endtask

  task automatic bus_rd(input logic [31:0] addr, output logic [31:0] d);
    bus.DADDR = addr;
    bus.RD    = 1'b1;
    @(negedge clk);
    bus.RD    = 1'b0;
    d         = bus.DATAI;
  endtask

  task automatic rd_reg(input logic [7:0] off, output logic [31:0] d);
    bus_rd(Base + 32'(off), d);
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 200; i++) begin
      rd_reg(8'h04, s);
      if (s[4]) break;
    end
    check_eq({tag, "_done"}, {31'd0, s[4]}, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [31:0] irq_exp;
    int          n0;
`ifdef PIM_IRQ_EN
    irq_exp = 32'd1;
`else
    irq_exp = 32'd0;
`endif
    bus.DADDR = '0;
    bus.DATAO = '0;
    bus.BE    = 4'hF;
    bus.WR    = 1'b0;
    bus.RD    = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_datai", bus.DATAI, 32'd0);
    check_eq("rst_cmd_valid", {31'd0, bus.pim_cmd_valid}, 32'd0);
    check_eq("rst_rsp_ready", {31'd0, bus.pim_rsp_ready}, 32'd1);
    check_eq("rst_hlt", {31'd0, bus.HLT}, 32'd0);
    check_eq("rst_irq", {31'd0, bus.IRQ}, 32'd0);
    rst = 1'b0;
    rd_reg(8'h04, d);
    check_eq("rst_status", d, 32'h0000_0004);

    // Basic run: three commands echoed back with +1.
    pim_ready = 1'b1;
    issued.delete();
    bus_wr(8'h08, 32'h11);
    bus_wr(8'h08, 32'h22);
    bus_wr(8'h08, 32'h33);
    rd_reg(8'h04, d);
    check_eq("basic_pre_status", d, 32'h0000_0300);
    bus_wr(8'h00, 32'h1);
    wait_done("basic");
    rd_reg(8'h04, d);
    check_eq("basic_post_status", d, 32'h0003_001C);
    check_eq("basic_n_issued", 32'(issued.size()), 32'd3);
    if (issued.size() == 3) begin
      check_eq("basic_issue0", issued[0], 32'h11);
      check_eq("basic_issue1", issued[1], 32'h22);
      check_eq("basic_issue2", issued[2], 32'h33);
    end
    rd_reg(8'h0C, d);
    check_eq("basic_rsp0", d, 32'h12);
    rd_reg(8'h0C, d);
    check_eq("basic_rsp1", d, 32'h23);
    rd_reg(8'h0C, d);
    check_eq("basic_rsp2", d, 32'h34);
    @(negedge clk);
    check_eq("datai_returns_0", bus.DATAI, 32'd0);
    rd_reg(8'h0C, d);
    check_eq("basic_rsp_empty", d, 32'd0);
    bus_wr(8'h04, 32'h10);
    rd_reg(8'h04, d);
    check_eq("w1c_done", d, 32'h0000_0004);

    // Backpressure: ninth write stalls until a pop frees a slot.
    pim_ready = 1'b0;
    issued.delete();
    for (int i = 0; i < 8; i++) bus_wr(8'h08, 32'hA0 + 32'(i));
    rd_reg(8'h04, d);
    check_eq("bp_full_status", d, 32'h0000_0802);
    bus.DADDR = Base + 32'h08;
    bus.DATAO = 32'hA8;
    bus.WR    = 1'b1;
    #1;
    check_eq("bp_hlt_idle", {31'd0, bus.HLT}, 32'd1);
    @(negedge clk);
    bus.WR = 1'b0;
    rd_reg(8'h04, d);
    check_eq("bp_no_push", d, 32'h0000_0802);
    bus_wr(8'h00, 32'h1);
    check_eq("bp_cmd_valid", {31'd0, bus.pim_cmd_valid}, 32'd1);
    bus.DADDR = Base + 32'h08;
    bus.DATAO = 32'hA8;
    bus.WR    = 1'b1;
    #1;
    check_eq("bp_hlt_issue", {31'd0, bus.HLT}, 32'd1);
    pim_ready = 1'b1;
    #1;
    check_eq("bp_hlt_pop_frees", {31'd0, bus.HLT}, 32'd0);
    @(negedge clk);
    bus.WR    = 1'b0;
    pim_ready = 1'b0;
    rd_reg(8'h04, d);
    check_eq("bp_stored", d, 32'h0000_0803);
    if (issued.size() > 0) check_eq("bp_first_issue", issued[0], 32'hA0);
    else check_eq("bp_n_issued", 32'(issued.size()), 32'd1);

    // Response full: nine issued, no reads, eighth response closes ready.
    pim_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!bus.pim_rsp_ready) break;
      @(negedge clk);
    end
    check_eq("rf_ready_low", {31'd0, bus.pim_rsp_ready}, 32'd0);
    rd_reg(8'h04, d);
    check_eq("rf_status", d, 32'h0008_000D);
    rd_reg(8'h0C, d);
    check_eq("rf_head", d, 32'hA1);
    check_eq("rf_reopen", {31'd0, bus.pim_rsp_ready}, 32'd1);
    wait_done("rf");
    rd_reg(8'h04, d);
    check_eq("rf_done_status", d, 32'h0008_001C);
    for (int i = 0; i < 8; i++) begin
      rd_reg(8'h0C, d);
      check_eq($sformatf("rf_drain%0d", i), d, 32'hA2 + 32'(i));
    end
    pim_ready = 1'b0;

    // Flush during WAIT with two responses outstanding; done still set from before.
    rsp_lat   = 20;
    pim_ready = 1'b1;
    n0        = n_hs;
    bus_wr(8'h08, 32'h51);
    bus_wr(8'h08, 32'h52);
    bus_wr(8'h00, 32'h1);
    repeat (3) @(negedge clk);
    rd_reg(8'h04, d);
    check_eq("fl_wait_status", d, 32'h0000_0015);
    bus_wr(8'h00, 32'h2);
    check_eq("fl_cmd_valid", {31'd0, bus.pim_cmd_valid}, 32'd0);
    rd_reg(8'h04, d);
    check_eq("fl_status", d, 32'h0000_0004);
    repeat (30) @(negedge clk);
    check_eq("fl_late_hs", 32'(n_hs - n0), 32'd2);
    rd_reg(8'h04, d);
    check_eq("fl_dropped", d, 32'h0000_0004);
    rd_reg(8'h0C, d);
    check_eq("fl_rsp_empty", d, 32'd0);
    pim_ready = 1'b0;
    rsp_lat   = 2;

    // Decode corner cases.
    bus_wr(8'h08, 32'h77, 4'h3);
    rd_reg(8'h04, d);
    check_eq("be_partial_ignored", d, 32'h0000_0004);
    bus_wr(8'h18, 32'hFFFF_FFFF);
    rd_reg(8'h14, d);
    check_eq("undef_rd", d, 32'd0);
`ifdef PIM_IRQ_EN
    bus_wr(8'h10, 32'h1);
`endif
    rd_reg(8'h10, d);
    check_eq("irqen_rd", d, irq_exp);

    // GO with empty FIFO only sets done; IRQ follows one cycle later.
    bus_wr(8'h00, 32'h1);
    check_eq("irq_lag", {31'd0, bus.IRQ}, 32'd0);
    @(negedge clk);
    check_eq("irq_set", {31'd0, bus.IRQ}, irq_exp);
    rd_reg(8'h04, d);
    check_eq("go_empty_done", d, 32'h0000_0014);
    bus_rd(32'h0000_0804, d);
    check_eq("unsel_rd", d, 32'd0);
    bus_wr(8'h04, 32'h10);
    check_eq("irq_w1c", {31'd0, bus.IRQ}, 32'd0);
    rd_reg(8'h04, d);
    check_eq("w1c_status", d, 32'h0000_0004);

    // CLR and GO together: CLR wins and clears a set done.
    bus_wr(8'h00, 32'h1);
    bus_wr(8'h00, 32'h3);
    rd_reg(8'h04, d);
    check_eq("clr_wins", d, 32'h0000_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
